// File: rtl/event_readout_pkg.sv
// rtl/event_readout_pkg.sv - shared constants and types for the event readout path
package event_readout_pkg;

  localparam logic [7:0]  CMD_STATUS    = 8'h01;
  localparam logic [7:0]  CMD_EVENT     = 8'h02;
  localparam logic [15:0] EMPTY_WORD    = 16'hFFFF;
  localparam int          WORDS_PER_EVT = 3;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  // Where the word being loaded into the shift register comes from
  typedef enum logic [1:0] {
    RESP_FILL,
    RESP_RAM,
    RESP_EMPTY
  } resp_t;

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - 2-flop synchroniser for SCK/SS/MOSI with SCK and SS edge strobes
module spi_pin_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic ss_n_i,
  input  logic mosi_i,
  output logic mosi_o,
  output logic sck_rise_o,
  output logic sck_fall_o,
  output logic ss_rise_o,
  output logic ss_fall_o
);

  // bit 0 = SCK, bit 1 = SS_N, bit 2 = MOSI; SS resets high so no false select
  logic [2:0] r_meta;
  logic [2:0] r_sync;
  logic [1:0] r_prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_meta <= 3'b010;
      r_sync <= 3'b010;
      r_prev <= 2'b10;
    end else begin
      r_meta <= {mosi_i, ss_n_i, sck_i};
      r_sync <= r_meta;
      r_prev <= r_sync[1:0];
    end
  end

  assign mosi_o     = r_sync[2];
  assign sck_rise_o =  r_sync[0] & ~r_prev[0];
  assign sck_fall_o = ~r_sync[0] &  r_prev[0];
  assign ss_rise_o  =  r_sync[1] & ~r_prev[1];
  assign ss_fall_o  = ~r_sync[1] &  r_prev[1];

endmodule

// File: rtl/event_spi_reader.sv
// rtl/event_spi_reader.sv - SPI mode-0 responder that drains event records from the event RAM
module event_spi_reader #(
  parameter int EVT_AW        = 8,
  parameter int WORD_W        = 16,
  parameter int WORDS_PER_EVT = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sck_i,
  input  logic              spi_ss_n_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  input  logic [EVT_AW-1:0] wr_evt_ptr_i,
  output logic [EVT_AW-1:0] rd_evt_ptr_o,
  output logic [EVT_AW+1:0] ram_rd_addr_o,
  input  logic [WORD_W-1:0] ram_rd_data_i,
  output logic              pop_o,
  output logic              busy_o
);

  import event_readout_pkg::*;

  localparam int AW  = EVT_AW + 2;
  localparam int BCW = $clog2(WORD_W);
  localparam int WCW = $clog2(WORDS_PER_EVT + 1);

  state_t            r_state, w_state_nxt;
  resp_t             r_resp;
  logic [BCW-1:0]    r_bit_cnt;
  logic [6:0]        r_cmd;
  logic [WORD_W-1:0] r_shift;
  logic              r_miso;
  logic              r_pop;
  logic              r_fetch_wait;
  logic [EVT_AW-1:0] r_rd_ptr;
  logic [EVT_AW-1:0] r_fill;
  logic [AW-1:0]     r_ram_addr;
  logic [AW-1:0]     r_base;
  logic [WCW-1:0]    r_word_idx;
  logic [WCW-1:0]    r_word_last;

  logic              w_mosi;
  logic              w_sck_rise;
  logic              w_sck_fall;
  logic              w_ss_rise;
  logic              w_ss_fall;
  logic [7:0]        w_cmd_byte;
  logic              w_cmd_done;
  logic              w_word_done;
  logic              w_last_word;
  logic [WCW-1:0]    w_word_nxt;
  logic [EVT_AW-1:0] w_fill;
  logic [AW-1:0]     w_base;
  logic [WORD_W-1:0] w_resp_word;

  spi_pin_sync u_pin_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sck_i      (spi_sck_i),
    .ss_n_i     (spi_ss_n_i),
    .mosi_i     (spi_mosi_i),
    .mosi_o     (w_mosi),
    .sck_rise_o (w_sck_rise),
    .sck_fall_o (w_sck_fall),
    .ss_rise_o  (w_ss_rise),
    .ss_fall_o  (w_ss_fall)
  );

  assign w_cmd_byte  = {r_cmd, w_mosi};
  assign w_cmd_done  = (r_bit_cnt == BCW'(7));
  assign w_word_done = (r_bit_cnt == BCW'(WORD_W - 1));
  assign w_last_word = (r_word_idx == r_word_last);
  assign w_word_nxt  = r_word_idx + 1'b1;
  assign w_fill      = wr_evt_ptr_i - r_rd_ptr;
  // rd*3 widened first so the top record index never overflows
  assign w_base      = (AW'(r_rd_ptr) << 1) + AW'(r_rd_ptr);

  always_comb begin
    w_resp_word = WORD_W'(EMPTY_WORD);
    case (r_resp)
      RESP_FILL:  w_resp_word = WORD_W'(r_fill);
      RESP_RAM:   w_resp_word = ram_rd_data_i;
      default:    w_resp_word = WORD_W'(EMPTY_WORD);
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_ss_fall) w_state_nxt = CMD;
      CMD: begin
        if (w_sck_rise && w_cmd_done) begin
          if (w_cmd_byte == CMD_STATUS || w_cmd_byte == CMD_EVENT) w_state_nxt = FETCH;
          else                                                     w_state_nxt = DONE;
        end
      end
      FETCH: if (r_fetch_wait) w_state_nxt = SHIFT;
      SHIFT: begin
        if (w_sck_rise && w_word_done) w_state_nxt = w_last_word ? DONE : FETCH;
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_ss_rise) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_resp       <= RESP_FILL;
      r_bit_cnt    <= '0;
      r_cmd        <= '0;
      r_shift      <= '0;
      r_miso       <= 1'b1;
      r_pop        <= 1'b0;
      r_fetch_wait <= 1'b0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_ram_addr   <= '0;
      r_base       <= '0;
      r_word_idx   <= '0;
      r_word_last  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pop   <= 1'b0;
      if (w_ss_rise) begin
        r_miso       <= 1'b1;
        r_fetch_wait <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_miso <= 1'b1;
            if (w_ss_fall) r_bit_cnt <= '0;
          end
          CMD: begin
            if (w_sck_rise) begin
              r_cmd     <= w_cmd_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_cmd_done) begin
                // writer pointer is captured here only, so late writes cannot skew the reply
                r_bit_cnt    <= '0;
                r_word_idx   <= '0;
                r_fetch_wait <= 1'b0;
                r_fill       <= w_fill;
                r_base       <= w_base;
                if (w_cmd_byte == CMD_EVENT) begin
                  r_word_last <= WCW'(WORDS_PER_EVT - 1);
                  if (w_fill == '0) begin
                    r_resp <= RESP_EMPTY;
                  end else begin
                    r_resp     <= RESP_RAM;
                    r_ram_addr <= w_base;
                  end
                end else begin
                  r_word_last <= '0;
                  r_resp      <= RESP_FILL;
                end
              end
            end
          end
          FETCH: begin
            // first cycle lets the RAM register the address, second captures its data
            if (r_fetch_wait) begin
              r_fetch_wait <= 1'b0;
              r_shift      <= w_resp_word;
            end else begin
              r_fetch_wait <= 1'b1;
            end
          end
          SHIFT: begin
            if (w_sck_fall) begin
              r_miso  <= r_shift[WORD_W-1];
              r_shift <= {r_shift[WORD_W-2:0], 1'b0};
            end
            if (w_sck_rise) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (w_word_done) begin
                r_bit_cnt <= '0;
                if (w_last_word) begin
                  if (r_resp == RESP_RAM) begin
                    r_pop    <= 1'b1;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                  end
                end else begin
                  r_word_idx <= w_word_nxt;
                  if (r_resp == RESP_RAM) r_ram_addr <= r_base + AW'(w_word_nxt);
                end
              end
            end
          end
          DONE: begin
            if (w_sck_fall) r_miso <= 1'b1;
          end
          default: r_miso <= 1'b1;
        endcase
      end
    end
  end

  assign spi_miso_o    = r_miso;
  assign rd_evt_ptr_o  = r_rd_ptr;
  assign ram_rd_addr_o = r_ram_addr;
  assign pop_o         = r_pop;
  assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_event_spi_reader.sv
// tb/tb_event_spi_reader.sv - randomized self-checking bench for event_spi_reader
`timescale 1ns/1ps
module tb_event_spi_reader;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck, mosi, ss_n_m, ss_n_s;
  logic        miso_m, miso_s;
  logic [7:0]  wr_m, rd_m;
  logic [9:0]  addr_m;
  logic [15:0] data_m;
  logic        pop_m, busy_m;
  logic [1:0]  wr_s, rd_s;
  logic [3:0]  addr_s;
  logic [15:0] data_s;
  logic        pop_s, busy_s;

  logic [15:0] mem [0:1023];
  int          ref_rd [2];
  int          ref_wr [2];
  int          pops   [2];
  int          n_checks, n_errors;

  always #5 clk = ~clk;

  event_spi_reader #(.EVT_AW(8), .WORD_W(16), .WORDS_PER_EVT(3)) u_dut (
    .clk_i (clk), .rst_i (rst), .spi_sck_i (sck), .spi_ss_n_i (ss_n_m), .spi_mosi_i (mosi),
    .spi_miso_o (miso_m), .wr_evt_ptr_i (wr_m), .rd_evt_ptr_o (rd_m),
    .ram_rd_addr_o (addr_m), .ram_rd_data_i (data_m), .pop_o (pop_m), .busy_o (busy_m)
  );

  // small-pointer instance so the pointer and address wrap is reachable in a short run
  event_spi_reader #(.EVT_AW(2), .WORD_W(16), .WORDS_PER_EVT(3)) u_dut_small (
    .clk_i (clk), .rst_i (rst), .spi_sck_i (sck), .spi_ss_n_i (ss_n_s), .spi_mosi_i (mosi),
    .spi_miso_o (miso_s), .wr_evt_ptr_i (wr_s), .rd_evt_ptr_o (rd_s),
    .ram_rd_addr_o (addr_s), .ram_rd_data_i (data_s), .pop_o (pop_s), .busy_o (busy_s)
  );

  always @(posedge clk) begin
    data_m <= mem[addr_m];
    data_s <= mem[addr_s];
    if (pop_m) pops[0] <= pops[0] + 1;
    if (pop_s) pops[1] <= pops[1] + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ptr_mask(input int sel);
    return (sel == 0) ? 255 : 3;
  endfunction

  task automatic set_wr(input int sel, input int v);
    ref_wr[sel] = v & ptr_mask(sel);
    wr_m = 8'(ref_wr[0]);
    wr_s = 2'(ref_wr[1]);
  endtask

  task automatic push_rec(input int sel, input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    int b;
    b = ref_wr[sel] * 3;
    mem[b] = w0; mem[b+1] = w1; mem[b+2] = w2;
    set_wr(sel, ref_wr[sel] + 1);
  endtask

  // Expected 48 response bits for a command given the current buffer state
  function automatic logic [47:0] model_resp(input int sel, input logic [7:0] cmd, output int npop);
    int fill, b;
    fill = (ref_wr[sel] - ref_rd[sel]) & ptr_mask(sel);
    b    = ref_rd[sel] * 3;
    npop = 0;
    if (cmd == 8'h01) return {16'(fill), 32'hFFFF_FFFF};
    if (cmd == 8'h02 && fill != 0) begin
      npop = 1;
      return {mem[b], mem[b+1], mem[b+2]};
    end
    return '1;
  endfunction

  task automatic spi_xfer(input int sel, input logic [7:0] cmd, input int nbits, input logic hold_ss,
                          input logic chg_wr, input int new_wr, output logic [47:0] rx);
    rx = '0;
    if (sel == 0) ss_n_m = 1'b0; else ss_n_s = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      mosi = cmd[i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    if (chg_wr) set_wr(sel, new_wr);
    for (int i = 0; i < nbits; i++) begin
      repeat (HALF) @(negedge clk);
      rx = {rx[46:0], (sel == 0) ? miso_m : miso_s};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    if (!hold_ss) begin
      repeat (HALF) @(negedge clk);
      ss_n_m = 1'b1;
      ss_n_s = 1'b1;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic do_txn(input int sel, input logic [7:0] cmd, input int nbits,
                        input logic chg_wr, input int new_wr, input string tag);
    logic [47:0] exp, rx, m;
    int np, p0;
    exp = model_resp(sel, cmd, np);
    p0  = pops[sel];
    spi_xfer(sel, cmd, nbits, 1'b0, chg_wr, new_wr, rx);
    if (nbits < 48) np = 0;
    m = (48'd1 << nbits) - 48'd1;
    check({tag, ":data"}, rx & m, (exp >> (48 - nbits)) & m);
    check({tag, ":pops"}, pops[sel] - p0, np);
    ref_rd[sel] = (ref_rd[sel] + np) & ptr_mask(sel);
    check({tag, ":rdptr"}, (sel == 0) ? rd_m : rd_s, ref_rd[sel]);
    check({tag, ":busy"}, (sel == 0) ? busy_m : busy_s, 0);
    check({tag, ":miso_idle"}, (sel == 0) ? miso_m : miso_s, 1);
  endtask

  initial begin
    logic [47:0] rx;
    logic [7:0]  c;
    logic        chg;
    int          k, nb, nw;

    n_checks = 0; n_errors = 0;
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss_n_m = 1'b1; ss_n_s = 1'b1;
    ref_rd[0] = 0; ref_rd[1] = 0; pops[0] = 0; pops[1] = 0;
    set_wr(0, 0); set_wr(1, 0);
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    repeat (5) @(negedge clk);

    check("rst:miso", miso_m, 1);
    check("rst:rdptr", rd_m, 0);
    check("rst:addr", addr_m, 0);
    check("rst:pop", pop_m, 0);
    check("rst:busy", busy_m, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sck = 1'b1; repeat (HALF) @(negedge clk);
      sck = 1'b0; repeat (HALF) @(negedge clk);
    end
    check("idle_sck:miso", miso_m, 1);
    check("idle_sck:busy", busy_m, 0);
    check("idle_sck:pops", pops[0], 0);

    set_wr(0, 5);
    do_txn(0, 8'h01, 48, 1'b0, 0, "status5");

    set_wr(0, 0);
    push_rec(0, 16'h0001, 16'h1234, 16'hABCD);
    do_txn(0, 8'h02, 48, 1'b0, 0, "event0");
    do_txn(0, 8'h02, 48, 1'b0, 0, "empty");

    push_rec(0, 16'($urandom), 16'($urandom), 16'($urandom));
    do_txn(0, 8'h02, 20, 1'b0, 0, "abort");
    do_txn(0, 8'h02, 48, 1'b0, 0, "reread");

    do_txn(0, 8'h7E, 48, 1'b0, 0, "badcmd");

    push_rec(0, 16'($urandom), 16'($urandom), 16'($urandom));
    do_txn(0, 8'h01, 48, 1'b1, ref_wr[0] + 7, "wr_midflight");
    set_wr(0, ref_rd[0] - 1);
    do_txn(0, 8'h01, 48, 1'b0, 0, "fill_wrap");

    for (int it = 0; it < 24; it++) begin
      nb = 48; chg = 1'b0; nw = 0;
      k = $urandom_range(0, 9);
      if ($urandom_range(0, 1) == 1) set_wr(0, ref_rd[0] + $urandom_range(0, 3));
      if (k < 3)       c = 8'h01;
      else if (k < 8)  c = 8'h02;
      else if (k == 8) c = 8'($urandom_range(3, 255));
      else begin
        c  = 8'h02;
        nb = $urandom_range(1, 47);
      end
      if ($urandom_range(0, 3) == 0) begin
        chg = 1'b1;
        nw  = $urandom_range(0, 255);
      end
      do_txn(0, c, nb, chg, nw, "rand");
    end

    for (int i = 0; i < 3; i++) begin
      push_rec(1, 16'($urandom), 16'($urandom), 16'($urandom));
      do_txn(1, 8'h02, 48, 1'b0, 0, "small_walk");
    end
    push_rec(1, 16'($urandom), 16'($urandom), 16'($urandom));
    check("small:wr_wrapped", wr_s, 0);
    do_txn(1, 8'h01, 48, 1'b0, 0, "small_status");
    do_txn(1, 8'h02, 48, 1'b0, 0, "small_wrap");
    check("small:rd_wrapped", rd_s, 0);

    push_rec(0, 16'h0F0F, 16'hF0F0, 16'h5555);
    spi_xfer(0, 8'h02, 5, 1'b1, 1'b0, 0, rx);
    check("pre_rst:busy", busy_m, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst:miso", miso_m, 1);
    check("mid_rst:rdptr", rd_m, 0);
    check("mid_rst:addr", addr_m, 0);
    check("mid_rst:pop", pop_m, 0);
    check("mid_rst:busy", busy_m, 0);
    @(negedge clk);
    rst = 1'b0;
    ss_n_m = 1'b1;
    ref_rd[0] = 0; ref_rd[1] = 0;
    set_wr(0, 0); set_wr(1, 0);
    repeat (10) @(negedge clk);
    do_txn(0, 8'h01, 48, 1'b0, 0, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
